// File: rtl/bnn_layer_sequencer.sv
// Time-shared XNOR-popcount sequencer for a two-layer binarized network.
// Streams weight words neuron-major, thresholds each neuron's popcount and collects the activations.
module bnn_layer_sequencer #(
   parameter int IN_WIDTH   = 64,
   parameter int CHUNK      = 16,
   parameter int L1_NEURONS = 8,
   parameter int L2_NEURONS = 2,
   parameter int THR_W      = 8,
   parameter int ADDR_W     = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [IN_WIDTH-1:0]           in_vec,
   input  logic [L1_NEURONS*THR_W-1:0]   thr_l1,
   input  logic [L2_NEURONS*THR_W-1:0]   thr_l2,
   output logic                          w_rd_en,
   output logic [ADDR_W-1:0]             w_addr,
   input  logic [CHUNK-1:0]              w_data,
   output logic                          busy,
   output logic                          done,
   output logic [L1_NEURONS-1:0]         l1_act,
   output logic [L2_NEURONS-1:0]         out_class
);

   localparam int CHUNKS    = IN_WIDTH / CHUNK;
   localparam int L1_WORDS  = L1_NEURONS * CHUNKS;
   localparam int LAST_ADDR = L1_WORDS + L2_NEURONS - 1;
   localparam int ACC_W     = $clog2(IN_WIDTH + 1);
   localparam int POP_W     = $clog2(CHUNK + 1);
   localparam int CMP_W     = (ACC_W + 1 > THR_W) ? ACC_W + 1 : THR_W;
   localparam int NMAX      = (L1_NEURONS > L2_NEURONS) ? L1_NEURONS : L2_NEURONS;
   localparam int NW        = (NMAX > 1) ? $clog2(NMAX) : 1;
   localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_RUN,
      S_L2_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [CW-1:0]         chunk_q;
   logic [NW-1:0]         neuron_q;
   logic [IN_WIDTH-1:0]   in_vec_q;
   logic                  tag_valid_q;
   logic                  tag_l2_q;
   logic [CW-1:0]         tag_chunk_q;
   logic [NW-1:0]         tag_neuron_q;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [L1_NEURONS-1:0] l1_act_q;
   logic [L2_NEURONS-1:0] out_class_q;
   logic                  accept;
   logic [CHUNK-1:0]      x_sel;
   logic [CHUNK-1:0]      match;
   logic [POP_W-1:0]      pop;
   logic [THR_W-1:0]      thr_sel;
   logic                  fire;
   logic                  last_chunk;

   assign accept    = (state_q == S_IDLE) && start;
   assign w_addr    = addr_q;
   assign l1_act    = l1_act_q;
   assign out_class = out_class_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      w_rd_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_L1_RUN;
         end
         S_L1_RUN: begin
            busy    = 1'b1;
            w_rd_en = 1'b1;
            if (addr_q == ADDR_W'(L1_WORDS - 1)) state_d = S_L2_RUN;
         end
         S_L2_RUN: begin
            busy    = 1'b1;
            w_rd_en = 1'b1;
            if (addr_q == ADDR_W'(LAST_ADDR)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address and (neuron, chunk) counters advance together; the address freezes on the final read.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         chunk_q  <= '0;
         neuron_q <= '0;
         in_vec_q <= '0;
      end else if (accept) begin
         addr_q   <= '0;
         chunk_q  <= '0;
         neuron_q <= '0;
         in_vec_q <= in_vec;
      end else if (w_rd_en) begin
         if (addr_q != ADDR_W'(LAST_ADDR)) addr_q <= addr_q + ADDR_W'(1);
         if (state_q == S_L1_RUN) begin
            if (chunk_q == CW'(CHUNKS - 1)) begin
               chunk_q  <= '0;
               neuron_q <= (neuron_q == NW'(L1_NEURONS - 1)) ? '0 : neuron_q + NW'(1);
            end else begin
               chunk_q <= chunk_q + CW'(1);
            end
         end else begin
            neuron_q <= neuron_q + NW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_q  <= 1'b0;
         tag_l2_q     <= 1'b0;
         tag_chunk_q  <= '0;
         tag_neuron_q <= '0;
      end else begin
         tag_valid_q  <= w_rd_en;
         tag_l2_q     <= (state_q == S_L2_RUN);
         tag_chunk_q  <= chunk_q;
         tag_neuron_q <= neuron_q;
      end
   end

   always_comb begin
      x_sel = '0;
      if (tag_l2_q) begin
         x_sel[L1_NEURONS-1:0] = l1_act_q;
      end else begin
         for (int c = 0; c < CHUNKS; c++) begin
            if (tag_chunk_q == CW'(c)) x_sel = in_vec_q[c*CHUNK +: CHUNK];
         end
      end
   end

   // Layer-2 rows only compare against the L1_NEURONS activation bits.
   for (genvar gi = 0; gi < CHUNK; gi++) begin : g_match
      if (gi < L1_NEURONS) begin : g_both
         assign match[gi] = ~(x_sel[gi] ^ w_data[gi]);
      end else begin : g_l1_only
         assign match[gi] = ~(x_sel[gi] ^ w_data[gi]) & ~tag_l2_q;
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < CHUNK; i++) pop = pop + POP_W'(match[i]);
      acc_d = ((tag_chunk_q == '0) ? '0 : acc_q) + ACC_W'(pop);
      thr_sel = '0;
      if (tag_l2_q) begin
         for (int m = 0; m < L2_NEURONS; m++) begin
            if (tag_neuron_q == NW'(m)) thr_sel = thr_l2[m*THR_W +: THR_W];
         end
      end else begin
         for (int n = 0; n < L1_NEURONS; n++) begin
            if (tag_neuron_q == NW'(n)) thr_sel = thr_l1[n*THR_W +: THR_W];
         end
      end
      fire       = CMP_W'({1'b0, acc_d}) >= CMP_W'(thr_sel);
      last_chunk = tag_l2_q || (tag_chunk_q == CW'(CHUNKS - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         l1_act_q    <= '0;
         out_class_q <= '0;
      end else if (accept) begin
         l1_act_q    <= '0;
         out_class_q <= '0;
      end else if (tag_valid_q) begin
         acc_q <= acc_d;
         if (last_chunk) begin
            for (int n = 0; n < L1_NEURONS; n++) begin
               if (!tag_l2_q && tag_neuron_q == NW'(n)) l1_act_q[n] <= fire;
            end
            for (int m = 0; m < L2_NEURONS; m++) begin
               if (tag_l2_q && tag_neuron_q == NW'(m)) out_class_q[m] <= fire;
            end
         end
      end
   end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Scoreboard bench for bnn_layer_sequencer: directed runs push expected results,
// a negedge monitor checks read stream, busy/done timing and results.
module tb_bnn_layer_sequencer;

   localparam int RUN_LEN = 36;
   localparam int N_READS = 34;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] in_vec = '0;
   logic [63:0] thr_l1 = '0;
   logic [15:0] thr_l2 = '0;
   logic        w_rd_en;
   logic [5:0]  w_addr;
   logic [15:0] w_data = '0;
   logic        busy;
   logic        done;
   logic [7:0]  l1_act;
   logic [1:0]  out_class;

   logic [15:0] wmem [0:63];
   logic [9:0]  exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   bnn_layer_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_vec    (in_vec),
      .thr_l1    (thr_l1),
      .thr_l2    (thr_l2),
      .w_rd_en   (w_rd_en),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .busy      (busy),
      .done      (done),
      .l1_act    (l1_act),
      .out_class (out_class)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   // Monitor: timing of every run is modelled from the accepted start.
   bit         model_busy = 1'b0;
   bit         zero_pending = 1'b0;
   bit         hold_valid = 1'b0;
   int         start_cyc = 0;
   logic [9:0] cur_exp = '0;
   logic [9:0] hold_exp = '0;

   always @(negedge clk) begin : monitor
      int rel;
      bit accept;
      rel    = cyc - start_cyc;
      accept = start && !rst && !model_busy;
      if (zero_pending) begin
         chk("reset_l1_act", l1_act, 0);
         chk("reset_out_class", out_class, 0);
      end
      if (model_busy) begin
         if (rel == 1) begin
            chk("clear_l1_act", l1_act, 0);
            chk("clear_out_class", out_class, 0);
         end
         if (rel <= N_READS) begin
            chk("rd_en", w_rd_en, 1);
            chk("rd_addr", w_addr, rel - 1);
         end else begin
            chk("rd_en_off", w_rd_en, 0);
         end
         if (rel < RUN_LEN) begin
            chk("busy", busy, 1);
            chk("done_early", done, 0);
         end else begin
            chk("done_pulse", done, 1);
            chk("busy_at_done", busy, 0);
            chk("l1_act", l1_act, cur_exp[9:2]);
            chk("out_class", out_class, cur_exp[1:0]);
            hold_exp   = cur_exp;
            hold_valid = 1'b1;
            model_busy = 1'b0;
         end
      end else begin
         chk("idle_busy", busy, 0);
         chk("idle_rd_en", w_rd_en, 0);
         chk("idle_done", done, 0);
         if (hold_valid && !zero_pending) begin
            chk("hold_l1_act", l1_act, hold_exp[9:2]);
            chk("hold_out_class", out_class, hold_exp[1:0]);
         end
      end
      zero_pending = rst;
      if (rst) begin
         model_busy = 1'b0;
         hold_valid = 1'b0;
      end
      if (accept) begin
         if (exp_q.size() == 0) begin
            chk("expectation_present", 0, 1);
         end else begin
            cur_exp    = exp_q.pop_front();
            start_cyc  = cyc;
            model_busy = 1'b1;
            hold_valid = 1'b0;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mem_fill(input logic [15:0] l1w, input logic [15:0] w32, input logic [15:0] w33);
      for (int a = 0; a < 64; a++) wmem[a] = (a < 32) ? l1w : 16'h0000;
      wmem[32] = w32;
      wmem[33] = w33;
   endtask

   task automatic run(input logic [63:0] iv, input logic [63:0] t1, input logic [15:0] t2,
                      input logic [7:0] el1, input logic [1:0] ecl);
      in_vec = iv;
      thr_l1 = t1;
      thr_l2 = t2;
      exp_q.push_back({el1, ecl});
      start = 1'b1;
      step();
      start  = 1'b0;
      in_vec = ~iv;
      step(40);
   endtask

   initial begin : stimulus
      logic [63:0] ones;
      logic [63:0] t1;
      ones = '1;
      mem_fill(16'hFFFF, 16'h00FF, 16'h00FF);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);

      run(ones, {8{8'h40}}, {2{8'h08}}, 8'hFF, 2'b11);
      run(ones, {8{8'h40}}, {2{8'h7F}}, 8'hFF, 2'b00);
      wmem[0] = 16'hFFFC;
      run(ones, {{7{8'h40}}, 8'h3E}, {2{8'h08}}, 8'hFF, 2'b11);
      wmem[33] = 16'h00FE;
      run(ones, {{7{8'h40}}, 8'h3F}, {2{8'h08}}, 8'hFE, 2'b10);
      mem_fill(16'h0000, 16'h0000, 16'h0000);
      run(ones, '0, {8'h00, 8'h09}, 8'hFF, 2'b10);
      run(ones, {8{8'h41}}, {2{8'h08}}, 8'h00, 2'b11);

      mem_fill(16'hFFFF, 16'h00FF, 16'h00FF);
      for (int n = 0; n < 8; n++) wmem[n*4+1] = 16'h0000;
      wmem[14] = 16'h7FFF;
      t1 = {8{8'h40}};
      t1[47:40] = 8'h41;
      run(64'hFFFF_FFFF_0000_FFFF, t1, {8'h08, 8'h06}, 8'hD7, 2'b01);

      // Start pulses while busy and during done must be ignored.
      mem_fill(16'hFFFF, 16'h00FF, 16'h00FF);
      in_vec = ones;
      thr_l1 = {8{8'h40}};
      thr_l2 = {2{8'h08}};
      exp_q.push_back({8'hFF, 2'b11});
      start = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         step();
         start = (i == 5 || i == 36);
      end

      // Abort by reset at cycle 10, with start also raised under reset.
      exp_q.push_back({8'hFF, 2'b11});
      start = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         step();
         start = (i == 11);
         rst   = (i == 10 || i == 11);
      end
      step(3);
      run(ones, {8{8'h40}}, {2{8'h08}}, 8'hFF, 2'b11);

      step(5);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_layer_sequencer.md
# bnn_layer_sequencer

Sequencer for the two-layer binarized network. It time-shares one XNOR-popcount accumulator across all layer-1 neurons and then all layer-2 neurons. It streams weight words from the weight memory, compares each neuron's popcount against its 8-bit threshold, and produces the layer-1 activation vector and the layer-2 class bits. It sits between the input capture logic and the classification output, and is fed by the threshold constants and the weight memory read port.

## Interface
- IN_WIDTH, 64: input vector bits; must be a multiple of CHUNK.
- CHUNK, 16: weight/input bits consumed per cycle; must be ≥ L1_NEURONS.
- L1_NEURONS, 8: layer-1 neuron count.
- L2_NEURONS, 2: layer-2 neuron count.
- THR_W, 8: threshold width.
- ADDR_W, 6: weight address width; must satisfy 2^ADDR_W ≥ L1_NEURONS*IN_WIDTH/CHUNK + L2_NEURONS.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin inference; accepted only in IDLE.
- in_vec  in  IN_WIDTH  input vector; sampled in the cycle start is accepted.
- thr_l1  in  L1_NEURONS*THR_W  packed thresholds; neuron n at [n*THR_W +: THR_W].
- thr_l2  in  L2_NEURONS*THR_W  same packing, layer 2.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  ADDR_W  weight word address.
- w_data  in  CHUNK  weight word; valid the cycle after its w_rd_en.
- busy  out  1  inference in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- l1_act  out  L1_NEURONS  layer-1 activations; bit n = neuron n.
- out_class  out  L2_NEURONS  layer-2 activations.

## Operation
- Constants: CHUNKS = IN_WIDTH/CHUNK (4). L1_WORDS = L1_NEURONS*CHUNKS (32).
- Address map:
  - Layer-1 neuron n, chunk c: addr n*CHUNKS+c.
  - Layer-2 neuron m: addr L1_WORDS+m.
  - For layer-2 rows, only the low L1_NEURONS bits of the word are used.
- States:
  - IDLE: waits for start. On start=1, latches in_vec, clears l1_act and out_class, and goes to L1_RUN.
  - L1_RUN: issues one read per cycle with addr 0..L1_WORDS-1, neuron-major. Goes to L2_RUN after addr L1_WORDS-1.
  - L2_RUN: issues addr L1_WORDS..L1_WORDS+L2_NEURONS-1, one per cycle, then goes to DRAIN.
  - DRAIN: no read; consumes the last returning word. Goes to DONE.
  - DONE: done=1 and busy=0 for one cycle, then returns to IDLE.
- Return side:
  - A one-cycle-delayed tag (valid, layer, neuron, chunk) follows each read.
  - On a valid tag: acc_next = (chunk==0 ? 0 : acc) + popcount(~(x ^ w_data)).
    - Layer 1: x = in_vec chunk c.
    - Layer 2: x = l1_act, and the popcount covers only the low L1_NEURONS bits.
  - On the last chunk of a neuron (layer 2 has a single chunk), the activation bit is registered as ({1'b0, acc_next} ≥ threshold). The comparison is unsigned at max(popcount width+1, THR_W) bits.
- Accumulator width: clog2(IN_WIDTH+1) = 7 bits; no overflow is possible.
- Layer-2 dependency: l1_act bit L1_NEURONS-1 is written at the same edge at which the first layer-2 read is issued, so l1_act is complete when layer-2 data returns. No stall is needed.
- A threshold above the maximum popcount (e.g. 0x7f for layer 2) never fires. A threshold of 0 always fires.
- start while busy, or in the DONE cycle, is ignored.
- thr_l1 and thr_l2 must be stable while busy. in_vec may change after acceptance.

## Timing
- Reset values: busy=0, done=0, w_rd_en=0, w_addr=0, l1_act=0, out_class=0, state IDLE.
- start accepted in cycle 0:
  - busy=1 in cycles 1..L1_WORDS+L2_NEURONS+1.
  - w_rd_en=1 in cycles 1..L1_WORDS+L2_NEURONS (34 consecutive reads).
  - Data returns in cycles 2..35.
  - done=1 in cycle L1_WORDS+L2_NEURONS+2 (36), with busy=0.
- l1_act bit n is valid from the cycle after its last chunk returns. out_class is valid with done and holds until the next accepted start.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values. The in-flight read is discarded. The next start performs a full, correct inference.
- rst and start in the same cycle: rst wins.
- w_addr holds its last value while w_rd_en=0.

## Test plan
- Reset: assert rst for 2 cycles mid-run → busy, done, w_rd_en, l1_act and out_class all 0 next cycle; no further reads.
- All-match: in_vec all ones, all weights all ones, thr_l1 all 0x40, layer-2 words 0xFF, thr_l2 all 0x08 → l1_act=0xFF, out_class=2'b11, done at cycle 36.
- Threshold boundary: neuron 0 weights differ from in_vec in exactly 2 bits (popcount 62).
  - thr 0x3e → l1_act[0]=1.
  - thr 0x3f → l1_act[0]=0.
- Read sequence: monitor w_rd_en and w_addr → exactly 34 strobes, addresses 0..33 on consecutive cycles, no reads in cycles 0, 35 or 36.
- Never-fire: thr_l2 all 0x7f with the all-match vectors → out_class=2'b00, l1_act=0xFF.
- Control robustness:
  - Pulse start at cycles 5 and 36 → ignored; exactly one done.
  - Then rst at cycle 10 of a new run, followed by a restart → done 36 cycles after restart start, with correct results.
